// File: rtl/vending_machine_pkg.sv
// Shared definitions for the vending controller: state codes and default item prices.
// No logic of its own; the price lookup helper is purely combinational.
// Imported by the FSM and the top-level datapath.
package vending_machine_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_COLLECT  = 3'd2;
    localparam logic [2:0] ST_CHECK    = 3'd3;
    localparam logic [2:0] ST_DISPENSE = 3'd4;
    localparam logic [2:0] ST_CHANGE   = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;
    localparam logic [2:0] ST_CANCEL   = 3'd7;

    localparam logic [7:0] PRICE0_DEF = 8'd5;
    localparam logic [7:0] PRICE1_DEF = 8'd8;
    localparam logic [7:0] PRICE2_DEF = 8'd10;
    localparam logic [7:0] PRICE3_DEF = 8'd15;

    // Pick one 8-bit price out of the packed {p3,p2,p1,p0} table.
    function automatic logic [7:0] price_sel(input logic [31:0] flat, input logic [1:0] sel);
        logic [7:0] p;
        case (sel)
            2'd0:    p = flat[7:0];
            2'd1:    p = flat[15:8];
            2'd2:    p = flat[23:16];
            default: p = flat[31:24];
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vending_machine_fsm.sv
// Transaction sequencer: state register, next-state decode and Moore status flags.
// State advances one step per clock; flags are pure decodes of the current state.
// No backpressure: cancel and in are sampled every cycle, cancel has top priority.
module vm_fsm
    import vending_machine_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_i,
    input  logic       cancel_i,
    input  logic       afford_i,
    output logic [2:0] state_o,
    output logic       dispense_o,
    output logic       start_o,
    output logic       done_o,
    output logic       ldm_o,
    output logic       check_o,
    output logic       rc_o,
    output logic       canceled_o,
    output logic       short_err_o
);

    logic [2:0] state_q;
    logic [2:0] state_d;

    // State register, cleared straight to IDLE by reset at any time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; cancel wins over every other condition while a session is open.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (in_i) state_d = ST_START;
            ST_START:    state_d = cancel_i ? ST_CANCEL : ST_COLLECT;
            ST_COLLECT: begin
                if (cancel_i)   state_d = ST_CANCEL;
                else if (!in_i) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cancel_i)      state_d = ST_CANCEL;
                else if (afford_i) state_d = ST_DISPENSE;
                else               state_d = ST_CANCEL;
            end
            ST_DISPENSE: state_d = ST_CHANGE;
            ST_CHANGE:   state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            ST_CANCEL:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Status flags from the current state, plus the shortfall strobe seen during CHECK.
    always_comb begin
        start_o     = (state_q == ST_START);
        ldm_o       = (state_q == ST_COLLECT);
        check_o     = (state_q == ST_CHECK);
        dispense_o  = (state_q == ST_DISPENSE);
        rc_o        = (state_q == ST_CHANGE);
        done_o      = (state_q == ST_DONE);
        canceled_o  = (state_q == ST_CANCEL);
        short_err_o = (state_q == ST_CHECK) && !cancel_i && !afford_i;
        state_o     = state_q;
    end

endmodule

// File: rtl/vending_machine_top.sv
// Vending controller top: coin accumulator, item select, price compare, change/refund register.
// Coins add to the balance on the same edge they are presented; change is valid one cycle after DISPENSE/CANCEL.
// No backpressure: a coin that would overflow the 8-bit balance is dropped and flagged on error.
module vending_machine_top
    import vending_machine_pkg::*;
#(
    parameter logic [7:0] PRICE0 = PRICE0_DEF,
    parameter logic [7:0] PRICE1 = PRICE1_DEF,
    parameter logic [7:0] PRICE2 = PRICE2_DEF,
    parameter logic [7:0] PRICE3 = PRICE3_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  money,
    input  logic [1:0]  Psel,
    input  logic        cancel,
    input  logic        in,
    output logic        dispense,
    output logic        start,
    output logic        done,
    output logic        ldM,
    output logic        check,
    output logic        RC,
    output logic        canceled,
    output logic        error,
    output logic [31:0] item_price_flat,
    output logic [7:0]  total_balance,
    output logic [7:0]  Return_change,
    output logic [2:0]  state
);

    logic [7:0] bal_q, bal_d;
    logic [7:0] rc_q,  rc_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] price;
    logic [8:0] coin_sum;
    logic       collecting;
    logic       coin_ok;
    logic       coin_ovf;
    logic       afford;
    logic       short_err;

    assign item_price_flat = {PRICE3, PRICE2, PRICE1, PRICE0};
    assign price           = price_sel(item_price_flat, sel_q);
    assign afford          = (bal_q >= price);

    // Nine-bit sum exposes the carry so an overflowing coin can be rejected cleanly.
    assign collecting = (state == ST_START) || (state == ST_COLLECT);
    assign coin_sum   = {1'b0, bal_q} + {6'd0, money};
    assign coin_ok    = collecting && in && !cancel && (money != 3'd0);
    assign coin_ovf   = coin_ok && coin_sum[8];

    assign error         = coin_ovf || short_err;
    assign total_balance = bal_q;
    assign Return_change = rc_q;

    vm_fsm u_fsm (
        .clk         (clk),
        .reset       (reset),
        .in_i        (in),
        .cancel_i    (cancel),
        .afford_i    (afford),
        .state_o     (state),
        .dispense_o  (dispense),
        .start_o     (start),
        .done_o      (done),
        .ldm_o       (ldM),
        .check_o     (check),
        .rc_o        (RC),
        .canceled_o  (canceled),
        .short_err_o (short_err)
    );

    // Datapath next-state: balance, change and select updates keyed off the current state.
    always_comb begin
        bal_d = bal_q;
        rc_d  = rc_q;
        sel_d = sel_q;
        case (state)
            ST_IDLE: begin
                if (in) begin
                    bal_d = 8'd0;
                    rc_d  = 8'd0;
                end
            end
            ST_START, ST_COLLECT: begin
                sel_d = Psel;
                if (coin_ok && !coin_sum[8]) bal_d = coin_sum[7:0];
            end
            ST_DISPENSE: begin
                rc_d  = bal_q - price;
                bal_d = 8'd0;
            end
            ST_CANCEL: begin
                rc_d  = bal_q;
                bal_d = 8'd0;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any balance without recording a refund.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bal_q <= 8'd0;
            rc_q  <= 8'd0;
            sel_q <= 2'd0;
        end else begin
            bal_q <= bal_d;
            rc_q  <= rc_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: tb/tb_vending_machine_top.sv
// Bench for vending_machine_top: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations at key points.
module tb_vending_machine_top;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  money;
    logic [1:0]  Psel;
    logic        cancel;
    logic        in;
    logic        dispense, start, done, ldM, check, RC, canceled, error;
    logic [31:0] item_price_flat;
    logic [7:0]  total_balance, Return_change;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;
    bit running = 1'b0;

    // Reference model: phase numbers match the published state codes.
    int prices[4] = '{5, 8, 10, 15};
    int ms, mbal, mrc, msel;

    vending_machine_top dut (
        .clk             (clk),
        .reset           (reset),
        .money           (money),
        .Psel            (Psel),
        .cancel          (cancel),
        .in              (in),
        .dispense        (dispense),
        .start           (start),
        .done            (done),
        .ldM             (ldM),
        .check           (check),
        .RC              (RC),
        .canceled        (canceled),
        .error           (error),
        .item_price_flat (item_price_flat),
        .total_balance   (total_balance),
        .Return_change   (Return_change),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge, from the behavioural rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ms = 0; mbal = 0; mrc = 0; msel = 0;
        end else begin
            if ((ms == 1 || ms == 2) && in && !cancel && money != 0 && (mbal + money) <= 255)
                mbal = mbal + money;
            case (ms)
                0: if (in) begin ms = 1; mbal = 0; mrc = 0; end
                1: begin msel = Psel; ms = cancel ? 7 : 2; end
                2: begin msel = Psel; ms = cancel ? 7 : (!in ? 3 : 2); end
                3: ms = cancel ? 7 : ((mbal >= prices[msel]) ? 4 : 7);
                4: begin mrc = mbal - prices[msel]; mbal = 0; ms = 5; end
                5: ms = 6;
                6: ms = 0;
                default: begin mrc = mbal; mbal = 0; ms = 0; end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (running && !reset) begin
            automatic bit exp_err;
            exp_err = ((ms == 1 || ms == 2) && in && !cancel && money != 0 && (mbal + money) > 255)
                   || (ms == 3 && !cancel && mbal < prices[msel]);
            chk("state",         int'(state),         ms);
            chk("total_balance", int'(total_balance), mbal);
            chk("Return_change", int'(Return_change), mrc);
            chk("error",         int'(error),         int'(exp_err));
            chk("start",    int'(start),    int'(ms == 1));
            chk("ldM",      int'(ldM),      int'(ms == 2));
            chk("check",    int'(check),    int'(ms == 3));
            chk("dispense", int'(dispense), int'(ms == 4));
            chk("RC",       int'(RC),       int'(ms == 5));
            chk("done",     int'(done),     int'(ms == 6));
            chk("canceled", int'(canceled), int'(ms == 7));
            chk("item_price_flat", int'(item_price_flat), 32'h0F0A0805);
        end
    end

    task automatic drive(input bit i, input int m, input int p, input bit c);
        in     = i;
        money  = m[2:0];
        Psel   = p[1:0];
        cancel = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit i, input int m, input int p, input bit c);
        drive(i, m, p, c);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst state",    int'(state),         0);
        chk("rst balance",  int'(total_balance), 0);
        chk("rst change",   int'(Return_change), 0);
        chk("rst flags",    int'({dispense, start, done, ldM, check, RC, canceled, error}), 0);
        chk("rst prices",   int'(item_price_flat), 32'h0F0A0805);
        reset   = 1'b0;
        running = 1'b1;

        // Item 1 (price 8), exact payment.
        cyc(1, 0, 1, 0); chk("s1 start", int'(start), 1);
        cyc(1, 2, 1, 0); chk("s1 ldM", int'(ldM), 1);
        cyc(1, 5, 1, 0);
        cyc(1, 1, 1, 0); chk("s1 bal", int'(total_balance), 8);
        cyc(0, 0, 1, 0); chk("s1 check", int'(state), 3);
        drive(0, 0, 1, 0); #1; chk("s1 no err", int'(error), 0);
        tick(); chk("s1 dispense", int'(dispense), 1);
        tick(); chk("s1 RC", int'(RC), 1); chk("s1 change", int'(Return_change), 0);
        tick(); chk("s1 done", int'(done), 1);
        tick(); chk("s1 idle", int'(state), 0);

        // Item 3 (price 15), overpay by one.
        cyc(1, 0, 3, 0);
        cyc(1, 7, 3, 0);
        cyc(1, 7, 3, 0);
        cyc(1, 2, 3, 0); chk("s2 bal", int'(total_balance), 16);
        cyc(0, 0, 3, 0);
        tick(); chk("s2 dispense", int'(dispense), 1);
        tick(); chk("s2 change", int'(Return_change), 1);
        tick(); tick(); chk("s2 change held", int'(Return_change), 1);

        // Item 2 (price 10), shortfall refunds in full.
        cyc(1, 0, 2, 0); chk("s3 change cleared", int'(Return_change), 0);
        cyc(1, 2, 2, 0);
        cyc(1, 3, 2, 0);
        cyc(0, 0, 2, 0); chk("s3 check", int'(state), 3);
        #1; chk("s3 short err", int'(error), 1);
        tick(); chk("s3 cancel", int'(canceled), 1);
        tick(); chk("s3 refund", int'(Return_change), 5); chk("s3 idle", int'(state), 0);

        // Cancel wins over in=0 on the same edge.
        cyc(1, 0, 1, 0);
        cyc(1, 2, 1, 0);
        cyc(1, 5, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 1, 1); chk("s4 cancel prio", int'(state), 7);
        cyc(0, 0, 1, 0); chk("s4 refund", int'(Return_change), 8);

        // Cancel straight out of START, with a coin that must be ignored.
        cyc(1, 0, 0, 0);
        cyc(1, 4, 0, 1); chk("s5 cancel", int'(state), 7); chk("s5 bal", int'(total_balance), 0);
        cyc(0, 0, 0, 0); chk("s5 refund", int'(Return_change), 0);

        // Balance saturation: 36 x 7 = 252, next 7 dropped, 3 reaches 255.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 36; k++) cyc(1, 7, 0, 0);
        chk("s6 bal 252", int'(total_balance), 252);
        drive(1, 7, 0, 0); #1; chk("s6 ovf err", int'(error), 1);
        tick(); chk("s6 coin dropped", int'(total_balance), 252);
        cyc(1, 3, 0, 0); chk("s6 bal 255", int'(total_balance), 255);
        cyc(0, 0, 0, 0);
        tick(); tick(); chk("s6 change", int'(Return_change), 250);
        tick(); tick();

        // Asynchronous reset in the middle of COLLECT.
        cyc(1, 0, 1, 0);
        cyc(1, 3, 1, 0);
        cyc(1, 4, 1, 0); chk("s7 bal", int'(total_balance), 7);
        #3 reset = 1'b1;
        #1;
        chk("s7 async state", int'(state), 0);
        chk("s7 async bal",   int'(total_balance), 0);
        chk("s7 async change", int'(Return_change), 0);
        drive(0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick(); chk("s7 stays idle", int'(state), 0);
        tick();

        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
